key_ctrl: RTL and testbench
===========================

// Module: key_ctrl
// PURPOSE
//  Front-end controller for N_KEY asynchronous push-button inputs.
//  - Synchronises each key to clk.
//  - Debounces all keys with one shared sample-tick prescaler instead of one free-running counter per key.
//  - Sequences a per-key press / hold / auto-repeat state machine.
//  - Emits one-cycle press, release and repeat events to the command logic downstream.
// PARAMETERS
//  N_KEY      4     number of key inputs
//  TICK_CMAX  1000  clk cycles per sample tick (>=2)
//  DEB_TICKS  10    consecutive disagreeing ticks needed to accept a level change (>=1)
//  HOLD_TICKS 500   ticks a key must stay pressed before the first repeat (>=1)
//  RPT_TICKS  100   ticks between subsequent repeats (>=1)
// PORTS
//  clk      in   1      system clock
//  rst_n    in   1      asynchronous, active-low reset
//  en       in   1      1 = run; 0 = freeze prescaler, debouncers and FSMs
//  a_key    in   N_KEY  raw asynchronous key levels, 1 = pressed
//  tick     out  1      one-cycle sample strobe (shared timebase)
//  k_lvl    out  N_KEY  debounced key level
//  k_press  out  N_KEY  one-cycle pulse on debounced 0->1
//  k_rel    out  N_KEY  one-cycle pulse on debounced 1->0
//  k_rpt    out  N_KEY  one-cycle auto-repeat pulse
// BEHAVIOUR
//  Reset
//  - rst_n=0 clears all outputs, synchronisers, counters and FSMs immediately (asynchronous), including mid-operation.
//  Synchroniser
//  - 2-FF per key; the synchronised value is s_key.
//  Prescaler
//  - pcnt counts 0..TICK_CMAX-1, then wraps to 0.
//  - tick=1 for the single cycle in which pcnt==TICK_CMAX-1 and en=1.
//  - First tick after reset is on the TICK_CMAX-th enabled cycle.
//  - en=0: pcnt holds its value and no tick is issued.
//  Debounce (per key, evaluated only on tick)
//  - s_key==k_lvl: dcnt <= 0.
//  - s_key!=k_lvl and dcnt<DEB_TICKS-1: dcnt <= dcnt+1.
//  - s_key!=k_lvl and dcnt==DEB_TICKS-1: k_lvl toggles, dcnt <= 0, and k_press or k_rel pulses in the same cycle.
//  - Latency from input edge to k_lvl: 2 clk + between DEB_TICKS-1 and DEB_TICKS tick periods.
//  - A glitch shorter than DEB_TICKS ticks produces no change.
//  Repeat FSM (per key; rcnt is wide enough for max(HOLD_TICKS, RPT_TICKS))
//  - IDLE: on a press pulse -> HOLD, rcnt <= 0.
//  - HOLD: on each tick rcnt++. When rcnt reaches HOLD_TICKS: -> RPT, k_rpt pulses, rcnt <= 0.
//  - RPT: on each tick rcnt++. When rcnt reaches RPT_TICKS: k_rpt pulses, rcnt <= 0.
//  - From HOLD or RPT, a release pulse -> IDLE with no k_rpt in that cycle.
//  - Release takes priority over a repeat that is due in the same cycle.
//  Keys and enable
//  - Keys are fully independent. Simultaneous events on several keys pulse in the same cycle.
//  - en=0 freezes all state and outputs; pulse outputs are forced to 0 while en=0.
// TESTING  (TICK_CMAX=4, DEB_TICKS=3, HOLD_TICKS=5, RPT_TICKS=2, N_KEY=4)
//  1. Reset: release rst_n with a_key=0 -> all outputs 0; tick high at enabled cycles 4, 8, 12, ...
//  2. Clean press: a_key[0]=1 held -> k_lvl[0] rises on the 3rd tick that samples s_key=1.
//     k_press[0] is high for exactly that one cycle.
//     Then drop a_key[0] -> k_rel[0] one-cycle pulse 3 ticks later.
//  3. Glitch: a_key[1]=1 for 2 tick periods, then 0 -> k_lvl[1] stays 0 and no pulses occur.
//  4. Hold: keep key 2 pressed -> first k_rpt[2] 5 ticks after k_press[2], then every 2 ticks.
//     Release inside a repeat interval -> k_rel[2] pulses and no further k_rpt[2].
//  5. Simultaneous: a_key[3:0]=4'b1011 in the same cycle -> k_press=4'b1011 in one cycle.
//     Per-key repeat pulses then arrive in the same cycles.
//  6. Reset mid-repeat / enable: assert rst_n=0 during RPT -> outputs 0 without waiting for a clk edge.
//     After restart, drive en=0 for 20 cycles mid-debounce -> no tick and no state change.
//     Debounce resumes exactly where it stopped once en=1.

Source files
------------

// File: rtl/key_ctrl.sv
// Push-button front end: per-key 2-FF synchroniser, shared-tick debouncer and
// press/hold/auto-repeat sequencer emitting one-cycle press, release and repeat events.
module key_ctrl #(
   parameter int unsigned N_KEY      = 4,
   parameter int unsigned TICK_CMAX  = 1000,
   parameter int unsigned DEB_TICKS  = 10,
   parameter int unsigned HOLD_TICKS = 500,
   parameter int unsigned RPT_TICKS  = 100
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_KEY-1:0] a_key,
   output logic             tick,
   output logic [N_KEY-1:0] k_lvl,
   output logic [N_KEY-1:0] k_press,
   output logic [N_KEY-1:0] k_rel,
   output logic [N_KEY-1:0] k_rpt
);

   localparam int unsigned PW   = (TICK_CMAX > 1) ? $clog2(TICK_CMAX) : 1;
   localparam int unsigned DW   = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
   localparam int unsigned RMAX = (HOLD_TICKS > RPT_TICKS) ? HOLD_TICKS : RPT_TICKS;
   localparam int unsigned RW   = $clog2(RMAX + 1);

   localparam logic [PW-1:0] P_LAST = PW'(TICK_CMAX - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DEB_TICKS - 1);
   localparam logic [RW-1:0] H_LAST = RW'(HOLD_TICKS - 1);
   localparam logic [RW-1:0] R_LAST = RW'(RPT_TICKS - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StHold = 2'd1;
   localparam logic [1:0] StRpt  = 2'd2;

   logic [N_KEY-1:0] sync1;
   logic [N_KEY-1:0] s_key;
   logic [PW-1:0]    pcnt;

   // The synchroniser is frozen with everything else while en=0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         s_key <= '0;
      end else if (en) begin
         sync1 <= a_key;
         s_key <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt <= '0;
      end else if (en) begin
         pcnt <= (pcnt == P_LAST) ? '0 : pcnt + PW'(1);
      end
   end

   assign tick = en && (pcnt == P_LAST);

   for (genvar i = 0; i < N_KEY; i++) begin : g_key
      logic [DW-1:0] dcnt;
      logic [RW-1:0] rcnt;
      logic [1:0]    st;
      logic          lvl;
      logic          flip;
      logic          press_ev;
      logic          rel_ev;
      logic          rpt_ev;
      logic          press_q;
      logic          rel_q;
      logic          rpt_q;

      assign flip     = tick && (s_key[i] != lvl) && (dcnt == D_LAST);
      assign press_ev = flip && !lvl;
      assign rel_ev   = flip && lvl;
      // A release in the same tick suppresses a due repeat.
      assign rpt_ev   = tick && !rel_ev &&
                        (((st == StHold) && (rcnt == H_LAST)) ||
                         ((st == StRpt) && (rcnt == R_LAST)));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dcnt <= '0;
            lvl  <= 1'b0;
         end else if (tick) begin
            if ((s_key[i] == lvl) || (dcnt == D_LAST)) begin
               dcnt <= '0;
            end else begin
               dcnt <= dcnt + DW'(1);
            end
            if (flip) begin
               lvl <= ~lvl;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st   <= StIdle;
            rcnt <= '0;
         end else if (tick) begin
            case (st)
               StIdle: begin
                  if (press_ev) begin
                     st   <= StHold;
                     rcnt <= '0;
                  end
               end
               StHold: begin
                  if (rel_ev) begin
                     st <= StIdle;
                  end else if (rcnt == H_LAST) begin
                     st   <= StRpt;
                     rcnt <= '0;
                  end else begin
                     rcnt <= rcnt + RW'(1);
                  end
               end
               StRpt: begin
                  if (rel_ev) begin
                     st <= StIdle;
                  end else if (rcnt == R_LAST) begin
                     rcnt <= '0;
                  end else begin
                     rcnt <= rcnt + RW'(1);
                  end
               end
               default: st <= StIdle;
            endcase
         end
      end

      // Events are zero whenever tick is low, so pulses self-clear after one cycle.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rpt_q   <= 1'b0;
         end else begin
            press_q <= press_ev;
            rel_q   <= rel_ev;
            rpt_q   <= rpt_ev;
         end
      end

      assign k_lvl[i]   = lvl;
      assign k_press[i] = press_q && en;
      assign k_rel[i]   = rel_q && en;
      assign k_rpt[i]   = rpt_q && en;
   end

endmodule

// File: tb/tb_key_ctrl.sv
// Randomised and directed bench for key_ctrl, checked every cycle against a
// tick-counting behavioural model of the key front end.
module tb_key_ctrl;

   localparam int N  = 4;
   localparam int TC = 4;
   localparam int DB = 3;
   localparam int HT = 5;
   localparam int RT = 2;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         en    = 1'b0;
   logic [N-1:0] a_key = '0;
   logic         tick;
   logic [N-1:0] k_lvl, k_press, k_rel, k_rpt;

   int checks = 0;
   int errors = 0;

   key_ctrl #(
      .N_KEY(N), .TICK_CMAX(TC), .DEB_TICKS(DB), .HOLD_TICKS(HT), .RPT_TICKS(RT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .a_key(a_key),
      .tick(tick), .k_lvl(k_lvl), .k_press(k_press), .k_rel(k_rel), .k_rpt(k_rpt)
   );

   always #5 clk = ~clk;

   // Model: enabled-cycle count, sync pipe, consecutive disagreeing ticks,
   // and ticks elapsed since the accepted press of each held key.
   int           m_ecnt;
   logic [N-1:0] m_s1, m_s2, m_lvl, m_press, m_rel, m_rpt, m_held;
   int           m_dis [N];
   int           m_tsp [N];

   logic [4*N:0] dut_o, exp_o;
   assign dut_o = {tick, k_lvl, k_press, k_rel, k_rpt};
   assign exp_o = {rst_n && en && (m_ecnt % TC == TC - 1), m_lvl,
                   m_press & {N{en}}, m_rel & {N{en}}, m_rpt & {N{en}}};

   task automatic model_reset();
      m_ecnt = 0;
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_held = '0;
      m_press = '0; m_rel = '0; m_rpt = '0;
      for (int k = 0; k < N; k++) begin
         m_dis[k] = 0;
         m_tsp[k] = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         m_press = '0; m_rel = '0; m_rpt = '0;
         if (en) begin
            if (m_ecnt % TC == TC - 1) begin
               for (int k = 0; k < N; k++) begin
                  if (m_s2[k] != m_lvl[k]) begin
                     m_dis[k]++;
                     if (m_dis[k] == DB) begin
                        m_dis[k] = 0;
                        m_lvl[k] = ~m_lvl[k];
                        if (m_lvl[k]) begin
                           m_press[k] = 1'b1; m_held[k] = 1'b1; m_tsp[k] = 0;
                        end else begin
                           m_rel[k] = 1'b1; m_held[k] = 1'b0;
                        end
                     end
                  end else begin
                     m_dis[k] = 0;
                  end
                  if (m_held[k] && !m_press[k]) begin
                     m_tsp[k]++;
                     if (m_tsp[k] == HT || (m_tsp[k] > HT && (m_tsp[k] - HT) % RT == 0))
                        m_rpt[k] = 1'b1;
                  end
               end
            end
            m_ecnt++;
            m_s2 = m_s1;
            m_s1 = a_key;
         end
      end
   endtask

   task automatic test_reset();
      logic e;
      rst_n = 1'b0; en = 1'b1; a_key = '0;
      repeat (3) step();
      #1 rst_n = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         if (c > 1) step();
         @(negedge clk);
         e = (c % TC == 0);
         checks++;
         if (tick !== e || {k_lvl, k_press, k_rel, k_rpt} !== '0) begin
            errors++;
            $display("FAIL reset c=%0d tick=%b want %b outs=%h want 0", c, tick, e,
                     {k_lvl, k_press, k_rel, k_rpt});
         end
      end
   endtask

   task automatic test_press();
      int np = 0, nr = 0;
      a_key[0] = 1'b1;
      for (int i = 0; i < 80; i++) begin
         if (i == 40) a_key[0] = 1'b0;
         step();
         @(negedge clk);
         checks++;
         if (dut_o !== exp_o) begin
            errors++;
            $display("FAIL press i=%0d got %h want %h", i, dut_o, exp_o);
         end
         np += int'(k_press[0]);
         nr += int'(k_rel[0]);
      end
      checks++;
      if (np !== 1 || nr !== 1 || k_lvl[0] !== 1'b0) begin
         errors++;
         $display("FAIL press_count press=%0d rel=%0d lvl=%b want 1 1 0", np, nr, k_lvl[0]);
      end
   endtask

   task automatic test_glitch();
      int bad = 0;
      a_key[1] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (i == 2 * TC) a_key[1] = 1'b0;
         step();
         @(negedge clk);
         checks++;
         if (dut_o !== exp_o) begin
            errors++;
            $display("FAIL glitch i=%0d got %h want %h", i, dut_o, exp_o);
         end
         bad += int'(k_lvl[1] | k_press[1] | k_rel[1] | k_rpt[1]);
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL glitch_quiet activity=%0d want 0", bad);
      end
   endtask

   task automatic test_hold();
      int  n = 0, post_rel = 0;
      bit  started = 0, released = 0;
      int  gaps[$];
      a_key[2] = 1'b1;
      for (int i = 0; i < 130; i++) begin
         if (i == 70) a_key[2] = 1'b0;
         step();
         @(negedge clk);
         checks++;
         if (dut_o !== exp_o) begin
            errors++;
            $display("FAIL hold i=%0d got %h want %h", i, dut_o, exp_o);
         end
         if (k_rpt[2] && started) begin
            gaps.push_back(n);
            n = 0;
         end
         if (tick && started) n++;
         if (k_press[2]) begin
            started = 1; n = 0;
         end
         if (k_rel[2]) released = 1;
         else if (released && k_rpt[2]) post_rel++;
      end
      checks++;
      if (gaps.size() < 2 || gaps[0] !== HT) begin
         errors++;
         $display("FAIL hold_first nrpt=%0d first_gap=%0d want >=2 and %0d", gaps.size(),
                  (gaps.size() > 0) ? gaps[0] : -1, HT);
      end
      for (int g = 1; g < gaps.size(); g++) begin
         checks++;
         if (gaps[g] !== RT) begin
            errors++;
            $display("FAIL hold_gap idx=%0d got %0d want %0d", g, gaps[g], RT);
         end
      end
      checks++;
      if (!released || post_rel !== 0) begin
         errors++;
         $display("FAIL hold_release released=%0d rpts_after=%0d want 1 0", released, post_rel);
      end
   endtask

   task automatic test_simul();
      logic [N-1:0] first_press = '0;
      int bad_rpt = 0, nrpt = 0;
      a_key = 4'b1011;
      for (int i = 0; i < 70; i++) begin
         step();
         @(negedge clk);
         checks++;
         if (dut_o !== exp_o) begin
            errors++;
            $display("FAIL simul i=%0d got %h want %h", i, dut_o, exp_o);
         end
         if (first_press == '0 && k_press != '0) first_press = k_press;
         if (k_rpt != '0) begin
            nrpt++;
            if (k_rpt !== 4'b1011) bad_rpt++;
         end
      end
      checks++;
      if (first_press !== 4'b1011 || nrpt == 0 || bad_rpt !== 0) begin
         errors++;
         $display("FAIL simul_align press=%b want 1011 rpts=%0d misaligned=%0d", first_press,
                  nrpt, bad_rpt);
      end
   endtask

   task automatic test_reset_mid();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (dut_o !== '0) begin
         errors++;
         $display("FAIL reset_async got %h want 0", dut_o);
      end
      a_key = '0;
      repeat (2) step();
      @(negedge clk);
      checks++;
      if (dut_o !== '0) begin
         errors++;
         $display("FAIL reset_hold got %h want 0", dut_o);
      end
   endtask

   task automatic test_enable();
      int ntick = 0, rise = 0;
      rst_n = 1'b1; a_key[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         @(negedge clk);
         checks++;
         if (dut_o !== exp_o) begin
            errors++;
            $display("FAIL en_pre i=%0d got %h want %h", i, dut_o, exp_o);
         end
      end
      en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         @(negedge clk);
         checks++;
         if (dut_o !== exp_o) begin
            errors++;
            $display("FAIL en_frozen i=%0d got %h want %h", i, dut_o, exp_o);
         end
         ntick += int'(tick);
      end
      checks++;
      if (ntick !== 0 || k_lvl !== '0) begin
         errors++;
         $display("FAIL en_freeze ticks=%0d lvl=%b want 0 0000", ntick, k_lvl);
      end
      en = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         step();
         @(negedge clk);
         checks++;
         if (dut_o !== exp_o) begin
            errors++;
            $display("FAIL en_resume i=%0d got %h want %h", i, dut_o, exp_o);
         end
         if (rise == 0 && k_lvl[0]) rise = i;
      end
      // 10 enabled edges left pcnt at 2 and two samples counted; third lands 2 edges later.
      checks++;
      if (rise !== 2) begin
         errors++;
         $display("FAIL en_resume_point rise_cycle=%0d want 2", rise);
      end
   endtask

   task automatic test_random();
      int hold;
      for (int s = 0; s < 150; s++) begin
         a_key = N'($urandom);
         hold  = $urandom_range(1, 40);
         for (int i = 0; i < hold; i++) begin
            if (i == 3) en = ($urandom_range(0, 4) != 0);
            if (i == 13) en = 1'b1;
            step();
            @(negedge clk);
            checks++;
            if (dut_o !== exp_o) begin
               errors++;
               $display("FAIL random seg=%0d i=%0d got %h want %h", s, i, dut_o, exp_o);
            end
         end
      end
      en = 1'b1;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_press();
      test_glitch();
      test_hold();
      test_simul();
      test_reset_mid();
      test_enable();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
